// File: rtl/dma_rd_arbiter_pkg.sv
// Shared types and helpers for the DMA read-port arbiter.
// State encoding and a width helper for the round-robin pointer.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Width of an index into n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dma_rd_arbiter_rr_pick.sv
// Rotating-priority picker: the first set request at or after ptr wins,
// reported both one-hot and as an index.
module rr_pick
  import dma_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int            j;
  logic [PW-1:0] jw;

  // Scan from the farthest slot back to ptr so the nearest request is written last.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    jw    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j  = (int'(ptr) + k) % N;
      jw = PW'(j);
      if (req[jw]) begin
        gnt     = '0;
        gnt[jw] = 1'b1;
        idx     = jw;
        valid   = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/dma_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_REQ DMA requesters;
// one burst outstanding, R beats routed back to the requester that owns it.
module dma_rd_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 64,
  parameter int ID_W    = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NUM_REQ-1:0]        s_arvalid,
  output logic [NUM_REQ-1:0]        s_arready,
  input  logic [NUM_REQ*ID_W-1:0]   s_arid,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]      s_arlen,
  input  logic [NUM_REQ*3-1:0]      s_arsize,
  input  logic [NUM_REQ*2-1:0]      s_arburst,
  input  logic [NUM_REQ*4-1:0]      s_arcache,
  output logic [NUM_REQ-1:0]        s_rvalid,
  input  logic [NUM_REQ-1:0]        s_rready,
  output logic [ID_W-1:0]           s_rid,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ID_W-1:0]           m_arid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic [3:0]                m_arcache,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [ID_W-1:0]           m_rid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        grant
);

  localparam int PW = clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                m_arvalid_q, m_arvalid_d;
  logic [ID_W-1:0]     arid_q, arid_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic [3:0]          arcache_q, arcache_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PW-1:0]       pick_idx;
  logic                pick_valid;
  logic                in_data;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (s_arvalid),
    .ptr   (rr_ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign in_data = (state_q == ST_DATA);

  // R channel is a pure pass-through to the owner; stray beats outside DATA are stalled.
  assign s_rvalid  = grant_q & {NUM_REQ{in_data & m_rvalid}};
  assign m_rready  = in_data & (|(s_rready & grant_q));
  assign s_rid     = m_rid & {ID_W{in_data}};
  assign s_rdata   = m_rdata & {DATA_W{in_data}};
  assign s_rresp   = m_rresp & {2{in_data}};
  assign s_rlast   = m_rlast & in_data;

  assign m_arvalid = m_arvalid_q;
  assign m_arid    = arid_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arburst = arburst_q;
  assign m_arcache = arcache_q;
  assign busy      = (state_q != ST_IDLE);
  assign grant     = grant_q;

  // Next-state logic: grant and capture in IDLE, present AR in ADDR, wait for rlast in DATA.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    m_arvalid_d = m_arvalid_q;
    arid_d      = arid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    arcache_d   = arcache_q;
    s_arready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          s_arready   = pick_gnt;
          owner_d     = pick_idx;
          grant_d     = pick_gnt;
          m_arvalid_d = 1'b1;
          arid_d      = s_arid[pick_idx*ID_W +: ID_W];
          araddr_d    = s_araddr[pick_idx*ADDR_W +: ADDR_W];
          arlen_d     = s_arlen[pick_idx*8 +: 8];
          arsize_d    = s_arsize[pick_idx*3 +: 3];
          arburst_d   = s_arburst[pick_idx*2 +: 2];
          arcache_d   = s_arcache[pick_idx*4 +: 4];
          state_d     = ST_ADDR;
        end else begin
          grant_d = '0;
        end
      end
      ST_ADDR: begin
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          state_d     = ST_DATA;
        end else begin
          m_arvalid_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (m_rvalid && m_rready && m_rlast) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        m_arvalid_d = 1'b0;
      end
    endcase
  end

  // State and AR field registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      m_arvalid_q <= 1'b0;
      arid_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= 8'd0;
      arsize_q    <= 3'd0;
      arburst_q   <= 2'd0;
      arcache_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      m_arvalid_q <= m_arvalid_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      arcache_q   <= arcache_d;
    end
  end

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Self-checking bench for dma_rd_arbiter: vector table of single bursts with an
// AR/R scoreboard, plus hand-written round-robin and mid-burst-reset sequences.
module tb_dma_rd_arbiter;
  localparam int N  = 3;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int DW = 32;

  logic            aclk;
  logic            aresetn;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*IW-1:0] s_arid;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [N*4-1:0]  s_arcache;
  logic [IW-1:0]   s_rid;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            m_arvalid, m_arready;
  logic [IW-1:0]   m_arid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic [3:0]      m_arcache;
  logic            m_rvalid, m_rready;
  logic [IW-1:0]   m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            busy;
  logic [N-1:0]    grant;

  dma_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arcache(s_arcache),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .busy(busy), .grant(grant)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int           req;
    logic [63:0]  addr;
    logic [7:0]   len;
    int           err_beat;
    bit           toggle;
    int           ar_delay;
    logic [N-1:0] exp_grant;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [3:0]  cache;
  } ar_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  vec_t    vecs[5];
  int      n_vec = 0;
  int      n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s_arvalid = '0; s_rready = '0; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0; s_arcache = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic drive_req(input int r, input logic [63:0] addr, input logic [7:0] len);
    s_arvalid[r]           = 1'b1;
    s_araddr[r*AW +: AW]   = addr;
    s_arlen[r*8 +: 8]      = len;
    s_arid[r*IW +: IW]     = 4'(r + 4);
    s_arsize[r*3 +: 3]     = 3'(r);
    s_arburst[r*2 +: 2]    = 2'b01;
    s_arcache[r*4 +: 4]    = 4'(r + 1);
  endtask

  // One complete burst for a single requester, entered and left just after a rising edge.
  task automatic run_vec(input vec_t v);
    ar_exp_t     a;
    r_exp_t      e;
    int          cyc;
    int          beat;
    logic        rr;
    logic [31:0] pat;
    drive_req(v.req, v.addr, v.len);
    ar_q.push_back('{v.addr, v.len, 4'(v.req + 4), 3'(v.req), 4'(v.req + 1)});
    cyc = 0;
    @(negedge aclk);
    while (s_arready == '0 && cyc < 20) begin
      tick(); @(negedge aclk); cyc++;
    end
    chk("ar_grant", 64'(s_arready), 64'(v.exp_grant));
    chk("busy_at_grant", 64'(busy), 64'd0);
    tick();
    s_arvalid = '0; s_rready = '1; m_arready = (v.ar_delay == 0);
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hDEAD_BEEF;
    a = ar_q.pop_front();
    @(negedge aclk);
    chk("ar_latency", 64'(m_arvalid), 64'd1);
    chk("grant_addr", 64'(grant), 64'(v.exp_grant));
    for (int k = 0; k < v.ar_delay; k++) begin
      chk("stall_araddr", m_araddr, a.addr);
      chk("stall_arvalid", 64'(m_arvalid), 64'd1);
      chk("stall_s_arready", 64'(s_arready), 64'd0);
      chk("stall_no_rvalid", 64'(s_rvalid), 64'd0);
      chk("stall_no_rready", 64'(m_rready), 64'd0);
      tick();
      m_arready = (k == v.ar_delay - 1);
      @(negedge aclk);
    end
    chk("m_araddr", m_araddr, a.addr);
    chk("m_arlen", 64'(m_arlen), 64'(a.len));
    chk("m_arid", 64'(m_arid), 64'(a.id));
    chk("m_arsize", 64'(m_arsize), 64'(a.size));
    chk("m_arburst", 64'(m_arburst), 64'd1);
    chk("m_arcache", 64'(m_arcache), 64'(a.cache));
    tick();
    m_arready = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(v.len) && cyc < 200) begin
      pat     = 32'hA500_0000 | (32'(v.req) << 16) | 32'(beat);
      rr      = v.toggle ? (cyc % 2 == 0) : 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = pat;
      m_rid    = a.id;
      m_rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
      m_rlast  = (beat == int'(v.len));
      s_rready = {N{~rr}};
      s_rready[v.req] = rr;
      if (r_q.size() == 0) begin
        r_q.push_back('{pat, m_rresp, m_rlast, a.id});
      end
      @(negedge aclk);
      chk("r_route", 64'(s_rvalid), 64'(v.exp_grant));
      chk("r_ready_mirror", 64'(m_rready), 64'(rr));
      if (m_rready) begin
        e = r_q.pop_front();
        chk("r_data", 64'(s_rdata), 64'(e.data));
        chk("r_resp", 64'(s_rresp), 64'(e.resp));
        chk("r_last", 64'(s_rlast), 64'(e.last));
        chk("r_id", 64'(s_rid), 64'(e.id));
        beat++;
      end
      tick();
      cyc++;
    end
    chk("beat_count", 64'(beat), 64'(int'(v.len) + 1));
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; s_rready = '0;
    @(negedge aclk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("grant_after", 64'(grant), 64'd0);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           order[6];
    int           cyc;
    logic [N-1:0] oh;
    vec_t         v0;

    vecs[0] = '{1, 64'h0000_0000_0000_1000, 8'd3, -1, 1'b0, 0, 3'b010};
    vecs[1] = '{0, 64'h0000_0000_0000_2000, 8'd7, -1, 1'b1, 0, 3'b001};
    vecs[2] = '{2, 64'h0000_0000_0000_3000, 8'd3,  1, 1'b0, 0, 3'b100};
    vecs[3] = '{1, 64'h0000_0000_0000_4000, 8'd1, -1, 1'b0, 5, 3'b010};
    vecs[4] = '{0, 64'hFFFF_FFFF_0000_0040, 8'd0, -1, 1'b0, 0, 3'b001};
    order   = '{0, 1, 2, 0, 1, 2};

    aresetn = 1'b0;
    idle_inputs();
    @(negedge aclk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_araddr", m_araddr, 64'd0);
    chk("rst_s_arready", 64'(s_arready), 64'd0);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    // Three requesters held valid: strict rotation with one IDLE cycle between bursts.
    do_reset();
    for (int i = 0; i < N; i++) begin
      drive_req(i, 64'(32'h100 * (i + 1)), 8'd0);
    end
    s_rready = '1;
    for (int n = 0; n < 6; n++) begin
      oh = '0;
      oh[order[n]] = 1'b1;
      cyc = 0;
      @(negedge aclk);
      while (s_arready == '0 && cyc < 10) begin
        tick(); @(negedge aclk); cyc++;
      end
      chk("rr_grant", 64'(s_arready), 64'(oh));
      chk("rr_gap", 64'(cyc), 64'd0);
      chk("rr_busy_gap", 64'(busy), 64'd0);
      tick();
      m_arready = 1'b1;
      @(negedge aclk);
      chk("rr_araddr", m_araddr, 64'(32'h100 * (order[n] + 1)));
      chk("rr_busy", 64'(busy), 64'd1);
      tick();
      m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'(n);
      @(negedge aclk);
      chk("rr_rvalid", 64'(s_rvalid), 64'(oh));
      chk("rr_rdata", 64'(s_rdata), 64'(n));
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0;
    end
    s_arvalid = '0;

    // Leave the pointer at 1, then reset in the middle of a req1 burst.
    v0 = '{0, 64'h0000_0000_0000_5000, 8'd0, -1, 1'b0, 0, 3'b001};
    tick();
    run_vec(v0);
    drive_req(1, 64'h6000, 8'd3);
    @(negedge aclk);
    chk("mid_grant", 64'(s_arready), 64'd2);
    tick();
    s_arvalid = '0; m_arready = 1'b1;
    @(negedge aclk);
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'd1; s_rready = '1;
    @(negedge aclk);
    chk("mid_beat1", 64'(s_rvalid), 64'd2);
    tick();
    m_rdata = 32'd2;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_rvalid", 64'(s_rvalid), 64'd0);
    chk("arst_rready", 64'(m_rready), 64'd0);
    chk("arst_rdata", 64'(s_rdata), 64'd0);
    chk("arst_arvalid", 64'(m_arvalid), 64'd0);
    chk("arst_araddr", m_araddr, 64'd0);
    chk("arst_arlen", 64'(m_arlen), 64'd0);
    tick();
    aresetn = 1'b1; m_rvalid = 1'b0;
    drive_req(0, 64'h7000, 8'd0);
    drive_req(2, 64'h8000, 8'd0);
    @(negedge aclk);
    chk("post_rst_ptr0", 64'(s_arready), 64'd1);
    tick();
    s_arvalid[0] = 1'b0; m_arready = 1'b1;
    @(negedge aclk);
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
    @(negedge aclk);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge aclk);
    chk("post_rst_req2", 64'(s_arready), 64'd4);
    tick();
    s_arvalid = '0; m_arready = 1'b1;
    @(negedge aclk);
    chk("post_rst_araddr2", m_araddr, 64'h8000);
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
    @(negedge aclk);
    chk("post_rst_route2", 64'(s_rvalid), 64'd4);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge aclk);
    chk("final_idle", 64'(busy), 64'd0);
    chk("sb_empty", 64'(r_q.size() + ar_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
